// File: rtl/gpu_pix_pack.sv
// gpu_pix_pack: packs RGB666 pixel runs into monochrome bitmap words by
// comparing each pixel against a programmed foreground colour, and decodes
// a single pixel to a 6-bit gray level. Command interface (sel/go/busy/y)
// matches the gpu block.
// Optional feature: define GPU_PIX_PACK_ERRCNT_EN to build the saturating
// count of pixels that match neither colour (read/clear through sel=2).
module gpu_pix_pack #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       sel,
    input  logic             go,
    output logic             busy,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] pix,
    input  logic             pix_valid,
    output logic             pix_ready
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        GRAY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [WIDTH-1:0] fg;
    logic [WIDTH-1:0] bg;
    logic [CW-1:0]    remaining;
    logic [CW-1:0]    pack_len;
    logic [4:0]       req_n;
    logic             xfer;
    logic             is_fg;
    logic             is_err;
    logic [7:0]       gray_sum;
    logic [WIDTH-1:0] err_value;

    assign xfer   = pix_valid & pix_ready;
    assign is_fg  = (pix == fg);
    assign is_err = (pix != fg) && (pix != bg);
    assign req_n  = a[4:0];

    // Pack length: zero or anything longer than a word means a full word
    always_comb begin
        pack_len = CW'(WIDTH);
        if (req_n != 5'd0 && 32'(req_n) <= WIDTH)
            pack_len = CW'(req_n);
    end

    // Gray level: (r + 2g + b) / 4, fits in 8 bits without overflow
    always_comb begin
        gray_sum = {2'b00, pix[17:12]} + {1'b0, pix[11:6], 1'b0} + {2'b00, pix[5:0]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; go is honoured only while idle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (go) begin
                    case (sel)
                        2'd1:    state_next = PACK;
                        2'd3:    state_next = GRAY;
                        default: state_next = DONE;
                    endcase
                end
            end
            PACK: if (xfer && remaining == CW'(1)) state_next = DONE;
            GRAY: if (xfer) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; ready drops in the same cycle the last pixel moves
    always_comb begin
        busy      = (state != IDLE);
        pix_ready = (state == PACK) || (state == GRAY);
    end

    // Colour registers, result word and pack counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fg        <= '0;
            bg        <= '0;
            y         <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        case (sel)
                            2'd0: begin
                                fg <= a;
                                bg <= b;
                            end
                            2'd1: begin
                                y         <= '0;
                                remaining <= pack_len;
                            end
                            2'd2: y <= err_value;
                            default: ;
                        endcase
                    end
                end
                PACK: begin
                    if (xfer) begin
                        y         <= {y[WIDTH-2:0], is_fg};
                        remaining <= remaining - CW'(1);
                    end
                end
                GRAY: if (xfer) y <= {{(WIDTH-6){1'b0}}, gray_sum[7:2]};
                default: ;
            endcase
        end
    end

`ifdef GPU_PIX_PACK_ERRCNT_EN
    logic [WIDTH-1:0] err_cnt;

    assign err_value = err_cnt;

    // Saturating count of packed pixels matching neither colour; sel=2 with a[0] clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (state == IDLE && go && sel == 2'd2 && a[0])
            err_cnt <= '0;
        else if (state == PACK && xfer && is_err && err_cnt != {WIDTH{1'b1}})
            err_cnt <= err_cnt + 1'b1;
    end
`else
    logic unused_err;

    assign err_value  = '0;
    assign unused_err = is_err;
`endif

endmodule

// File: tb/tb_gpu_pix_pack.sv
// Directed testbench for gpu_pix_pack: colour setup, full and short packs,
// stalls, gray decode, error count read/clear, ignored go while busy and
// asynchronous reset in the middle of a pack.
module tb_gpu_pix_pack;

    localparam int W = 18;

    logic         clk;
    logic         rst_n;
    logic [1:0]   sel;
    logic         go;
    logic         busy;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic [W-1:0] pix;
    logic         pix_valid;
    logic         pix_ready;

    int passed;
    int total;
    logic [W-1:0] pix_seq [0:31];

    localparam logic [W-1:0] FG  = 18'o777371;
    localparam logic [W-1:0] BG  = 18'o001116;
    localparam logic [W-1:0] PAT = 18'o520252;

    gpu_pix_pack #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sel(sel),
        .go(go),
        .busy(busy),
        .a(a),
        .b(b),
        .y(y),
        .pix(pix),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference
    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse go for one cycle with the given command
    task automatic apply_stimulus(input logic [1:0] s, input logic [W-1:0] av, input logic [W-1:0] bv);
        sel = s;
        a   = av;
        b   = bv;
        go  = 1'b1;
        tick();
        go  = 1'b0;
    endtask

    // Offer pix_seq[0..n_offer-1] while busy, with an optional stall after stall_after transfers
    task automatic stream(input int n_offer, input int stall_after, input int stall_len,
                          output int xfers, output int bcyc);
        int idx;
        int stall;
        int guard;
        idx   = 0;
        stall = 0;
        guard = 0;
        bcyc  = 0;
        while (busy === 1'b1 && guard < 200) begin
            guard++;
            bcyc++;
            if (stall_len > 0 && idx == stall_after && stall < stall_len) begin
                pix_valid = 1'b0;
                stall++;
            end else if (idx < n_offer) begin
                pix_valid = 1'b1;
                pix       = pix_seq[idx];
            end else begin
                pix_valid = 1'b0;
            end
            if (pix_valid && pix_ready === 1'b1) idx++;
            tick();
        end
        pix_valid = 1'b0;
        xfers     = idx;
        check_output("stream_timeout", 32'(guard >= 200), 32'd0);
    endtask

    initial begin
        int xf;
        int bc;
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        sel       = 2'd0;
        go        = 1'b0;
        a         = '0;
        b         = '0;
        pix       = '0;
        pix_valid = 1'b0;

        // Reset state
        #12;
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_y", 32'(y), 32'd0);
        check_output("reset_ready", 32'(pix_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Set colours: one busy cycle, y unchanged
        apply_stimulus(2'd0, FG, BG);
        check_output("setcol_busy", 32'(busy), 32'd1);
        check_output("setcol_ready", 32'(pix_ready), 32'd0);
        tick();
        check_output("setcol_idle", 32'(busy), 32'd0);
        check_output("setcol_y", 32'(y), 32'd0);

        // Full 18-pixel pack, first pixel to MSB; one extra pixel offered
        for (int i = 0; i < 19; i++)
            pix_seq[i] = (i < 18 && PAT[17 - i]) ? FG : BG;
        apply_stimulus(2'd1, 18'd0, 18'd0);
        stream(19, 0, 0, xf, bc);
        check_output("pack18_y", 32'(y), 32'(PAT));
        check_output("pack18_busy_cycles", 32'(bc), 32'd19);
        check_output("pack18_xfers", 32'(xf), 32'd18);

        // Short pack with a 3-cycle stall after the second pixel
        pix_seq[0] = FG; pix_seq[1] = BG; pix_seq[2] = FG;
        pix_seq[3] = FG; pix_seq[4] = BG; pix_seq[5] = FG;
        apply_stimulus(2'd1, 18'd5, 18'd0);
        stream(6, 2, 3, xf, bc);
        check_output("pack5_y", 32'(y), 32'b10110);
        check_output("pack5_xfers", 32'(xf), 32'd5);
        check_output("pack5_busy_cycles", 32'(bc), 32'd9);
        check_output("pack5_ready_low", 32'(pix_ready), 32'd0);

        // Gray decode of white
        pix_seq[0] = {6'd63, 6'd63, 6'd63};
        apply_stimulus(2'd3, 18'd0, 18'd0);
        stream(1, 0, 0, xf, bc);
        check_output("gray_white_y", 32'(y), 32'd63);
        check_output("gray_white_busy", 32'(bc), 32'd2);

        // Gray decode of a mixed pixel: (4 + 16 + 12) / 4 = 8
        pix_seq[0] = {6'd4, 6'd8, 6'd12};
        apply_stimulus(2'd3, 18'd0, 18'd0);
        stream(1, 0, 0, xf, bc);
        check_output("gray_mix_y", 32'(y), 32'd8);
        check_output("gray_mix_busy", 32'(bc), 32'd2);

        // Pack 4 with two pixels matching neither colour
        pix_seq[0] = FG; pix_seq[1] = 18'd1; pix_seq[2] = BG; pix_seq[3] = 18'd2;
        apply_stimulus(2'd1, 18'd4, 18'd0);
        stream(4, 0, 0, xf, bc);
        check_output("pack4_y", 32'(y), 32'b1000);

        // Read and clear the error count, then read again
        apply_stimulus(2'd2, 18'd1, 18'd0);
        check_output("errrd_busy", 32'(busy), 32'd1);
        tick();
        check_output("errrd_idle", 32'(busy), 32'd0);
`ifdef GPU_PIX_PACK_ERRCNT_EN
        check_output("errrd_first", 32'(y), 32'd2);
`else
        check_output("errrd_first", 32'(y), 32'd0);
`endif
        apply_stimulus(2'd2, 18'd0, 18'd0);
        tick();
        check_output("errrd_second", 32'(y), 32'd0);

        // go during PACK is ignored (it would swap the colours if accepted)
        apply_stimulus(2'd1, 18'd3, 18'd0);
        apply_stimulus(2'd0, BG, FG);
        check_output("gobusy_still_busy", 32'(busy), 32'd1);
        pix_seq[0] = FG; pix_seq[1] = FG; pix_seq[2] = BG;
        stream(3, 0, 0, xf, bc);
        check_output("gobusy_y", 32'(y), 32'b110);
        check_output("gobusy_idle", 32'(busy), 32'd0);
        pix_seq[0] = FG; pix_seq[1] = BG;
        apply_stimulus(2'd1, 18'd2, 18'd0);
        stream(2, 0, 0, xf, bc);
        check_output("gobusy_colours_kept", 32'(y), 32'b10);

        // Asynchronous reset after 3 of 10 pixels
        apply_stimulus(2'd1, 18'd10, 18'd0);
        pix       = FG;
        pix_valid = 1'b1;
        tick();
        tick();
        tick();
        pix_valid = 1'b0;
        check_output("midpack_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_y", 32'(y), 32'd0);
        check_output("rst_ready", 32'(pix_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Pack 2 after reset with fg = bg = 0
        pix_seq[0] = 18'd0; pix_seq[1] = 18'd5;
        apply_stimulus(2'd1, 18'd2, 18'd0);
        stream(2, 0, 0, xf, bc);
        check_output("postrst_y", 32'(y), 32'b10);
        check_output("postrst_busy_cycles", 32'(bc), 32'd3);
        check_output("postrst_xfers", 32'(xf), 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gpu_pix_pack.md
Name: gpu_pix_pack

Overview:
- Return path for the GPU pixel stream: accepts RGB666 pixels (the format the gpu block emits) over a valid/ready handshake.
- Packs runs of pixels back into monochrome bitmap words by comparing each pixel against a programmed foreground colour.
- Also decodes a single pixel to a 6-bit gray level.
- Sits between the LCD readback path and the CPU; its command interface (sel/go/busy/y/a/b) matches the gpu block so firmware drives both the same way.

Parameters:
- WIDTH, 18, data word width; pixel format is {r[17:12], g[11:6], b[5:0]}.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- sel  input  2  command select, sampled on go
- go  input  1  one-cycle command strobe
- busy  output  1  command in progress
- a  input  WIDTH  command operand A
- b  input  WIDTH  command operand B
- y  output  WIDTH  result; valid whenever busy=0
- pix  input  WIDTH  incoming pixel
- pix_valid  input  1  pixel present
- pix_ready  output  1  block accepts pixel this cycle (transfer when pix_valid & pix_ready)

Behaviour:
- Reset (async, rst_n=0): busy=0, y=0, pix_ready=0, fg=0, bg=0, bit count=0, error count=0, state=IDLE.
- States:
  - IDLE: pix_ready=0.
  - PACK: pix_ready=1.
  - GRAY: pix_ready=1.
  - DONE: 1 cycle, then IDLE.
- go is sampled only in IDLE. go while busy=1 is ignored; no queueing.
- Commands (sel captured with a/b on the go cycle):
  - 0, set colours: fg<=a, bg<=b. busy=1 for exactly one cycle (the cycle after go), y unchanged.
  - 1, pack: n = a[4:0]. n=0 or n>WIDTH means n=WIDTH. y<=0, enter PACK, busy=1 from the cycle after go.
    - Each transfer shifts y left one bit; LSB <= (pix==fg).
    - A pixel equal to neither fg nor bg increments the error count; it saturates at 2^WIDTH-1.
    - After the n-th transfer: DONE, busy falls one cycle later.
    - The first pixel lands at bit n-1, the last at bit 0; bits above n-1 are 0.
  - 2, read/clear error count: y <= error count. If a[0]=1, the count clears in the same cycle. busy=1 for one cycle.
  - 3, gray: enter GRAY and accept one pixel. y <= {12'b0, (r + 2*g + b) >> 2}. The sum uses 8-bit arithmetic with no overflow; the result is 6 bits. Then DONE.
- Transfers are accepted only in PACK/GRAY. With pix_valid=0 the block waits indefinitely, busy stays 1, and there is no timeout.
- The transfer on the final pixel and the drop of pix_ready are in the same cycle. No extra pixel is consumed.
- y updates only on shifts or command completion. It is stable from the falling edge of busy until the next go.
- A reset mid-PACK returns everything to reset values immediately; a partial word is discarded.
- Latency:
  - pack of n pixels with pix_valid held high: busy high for n+1 cycles.
  - gray: busy high for 2 cycles.

Optional Feature:
- Macro: GPU_PIX_PACK_ERRCNT_EN.
- Defined: error counter implemented as above. sel=2 returns the count and a[0] clears it.
- Undefined: no counter register. sel=2 returns y=0 with the same one-cycle busy; pack behaviour is otherwise identical.

Test Plan:
- Set colours then pack 18:
  - Stimulus: set a=18'o777371, b=18'o001116; pack a=0; stream pixels with fg at positions matching pattern 18'o520252 (first pixel = MSB), bg elsewhere, pix_valid held high.
  - Required: y=18'o520252 when busy falls; busy high 19 cycles; exactly 18 transfers.
- Short pack with stall:
  - Stimulus: pack a=5; pixels fg,bg,fg,fg,bg with pix_valid low for 3 cycles after the 2nd pixel.
  - Required: y=18'b10110; pix_ready low after the 5th transfer; the 6th offered pixel is not accepted.
- Gray decode:
  - Stimulus: pixel {6'd63,6'd63,6'd63} -> y=63. Pixel {6'd4,6'd8,6'd12} -> y=8. busy high 2 cycles each.
- Error count:
  - Stimulus: pack a=4 with 2 pixels equal to neither colour; sel=2 a=1, then sel=2 a=0.
  - Required: y=2, then y=0. With the macro undefined, both reads give y=0.
- go while busy: issue go during PACK.
  - Required: ignored; pack completes with the correct y and state returns to IDLE.
- Reset mid-pack:
  - Stimulus: drop rst_n after 3 of 10 pixels.
  - Required: busy=0, y=0, pix_ready=0 immediately (async). A following pack a=2 behaves normally with fg=bg=0.
